// File: rtl/bus_frame_receiver.sv
// Serial bus frame receiver: deframes start|src|dst|data|crc frames (MSB first), checks CRC-4,
// filters on destination address and presents accepted payloads with saturating counters.

`timescale 1ns/1ps

module bus_frame_receiver #(
  parameter logic [3:0]  MY_ADDR = 4'd1,
  parameter bit          PROMISC = 1'b0,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_in,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [3:0]        rx_src,
  output logic              crc_err,
  output logic              busy,
  output logic [7:0]        good_cnt,
  output logic [7:0]        err_cnt
);

  localparam logic [5:0] NibbleLast = 6'd3;
  localparam logic [5:0] DataLast   = 6'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSrc,
    StDst,
    StData,
    StCrc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [5:0]        cnt_q;
  logic [3:0]        src_q;
  logic [3:0]        dst_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        crc_rx_q;
  logic [3:0]        crc_q, crc_d;
  logic              crc_fb;

  logic              rx_valid_q;
  logic              crc_err_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [3:0]        rx_src_q;
  logic [7:0]        good_cnt_q;
  logic [7:0]        err_cnt_q;

  logic field_last;
  logic start;
  logic shift_en;
  logic crc_en;
  logic crc_ok;
  logic addr_ok;
  logic accept;
  logic crc_bad;

  // Last bit of the current field: 4-bit fields end at count 3, the payload at DATA_W-1.
  always_comb begin
    field_last = 1'b0;
    unique case (state_q)
      StSrc, StDst, StCrc: field_last = (cnt_q == NibbleLast);
      StData:              field_last = (cnt_q == DataLast);
      default:             field_last = 1'b0;
    endcase
  end

  assign crc_fb = bus_in ^ crc_q[3];
  assign crc_d  = {crc_q[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);

  assign crc_ok  = (crc_q == crc_rx_q);
  assign addr_ok = (dst_q == MY_ADDR) || PROMISC;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_in)     state_d = StSrc;
      StSrc:   if (field_last) state_d = StDst;
      StDst:   if (field_last) state_d = StData;
      StData:  if (field_last) state_d = StCrc;
      StCrc:   if (field_last) state_d = StDone;
      StDone:                  state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  // FSM decoded controls
  always_comb begin
    busy     = 1'b0;
    start    = 1'b0;
    shift_en = 1'b0;
    crc_en   = 1'b0;
    accept   = 1'b0;
    crc_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        start = bus_in;
      end
      StSrc, StDst, StData: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        crc_en   = 1'b1;
      end
      StCrc: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      StDone: begin
        busy    = 1'b1;
        accept  = crc_ok && addr_ok;
        crc_bad = !crc_ok;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Field shifting, CRC accumulation and the bit counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      crc_rx_q <= '0;
      crc_q    <= '0;
    end else begin
      if (shift_en) begin
        cnt_q <= field_last ? 6'd0 : cnt_q + 6'd1;
      end else begin
        cnt_q <= '0;
      end

      if (start) begin
        crc_q <= '0;
      end else if (crc_en) begin
        crc_q <= crc_d;
      end

      if (state_q == StSrc) begin
        src_q <= {src_q[2:0], bus_in};
      end
      if (state_q == StDst) begin
        dst_q <= {dst_q[2:0], bus_in};
      end
      if (state_q == StData) begin
        data_q <= {data_q[DATA_W-2:0], bus_in};
      end
      if (state_q == StCrc) begin
        crc_rx_q <= {crc_rx_q[2:0], bus_in};
      end
    end
  end

  // Result registers: pulses last one cycle, payload/source hold until the next accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_src_q   <= '0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      rx_valid_q <= accept;
      crc_err_q  <= crc_bad;
      if (accept) begin
        rx_data_q <= data_q;
        rx_src_q  <= src_q;
        if (good_cnt_q != 8'hFF) begin
          good_cnt_q <= good_cnt_q + 8'd1;
        end
      end
      if (crc_bad && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign crc_err  = crc_err_q;
  assign rx_data  = rx_data_q;
  assign rx_src   = rx_src_q;
  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Scoreboard bench for bus_frame_receiver: an address-filtering node and a promiscuous node
// share one bus; expected pulses are queued at stimulus time and checked by per-node monitors.

`timescale 1ns/1ps

module tb_bus_frame_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_in;

  logic        r0_valid, r0_err, r0_busy;
  logic [63:0] r0_data;
  logic [3:0]  r0_src;
  logic [7:0]  r0_good, r0_errc;

  logic        r1_valid, r1_err, r1_busy;
  logic [63:0] r1_data;
  logic [3:0]  r1_src;
  logic [7:0]  r1_good, r1_errc;

  bus_frame_receiver #(.MY_ADDR(4'd1), .PROMISC(1'b0), .DATA_W(64)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus_in  (bus_in),
    .rx_valid(r0_valid),
    .rx_data (r0_data),
    .rx_src  (r0_src),
    .crc_err (r0_err),
    .busy    (r0_busy),
    .good_cnt(r0_good),
    .err_cnt (r0_errc)
  );

  bus_frame_receiver #(.MY_ADDR(4'd1), .PROMISC(1'b1), .DATA_W(64)) dut_promisc (
    .clock   (clock),
    .reset   (reset),
    .bus_in  (bus_in),
    .rx_valid(r1_valid),
    .rx_data (r1_data),
    .rx_src  (r1_src),
    .crc_err (r1_err),
    .busy    (r1_busy),
    .good_cnt(r1_good),
    .err_cnt (r1_errc)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [63:0] data;
    logic [3:0]  src;
    logic [7:0]  good;
    logic [7:0]  errc;
    int unsigned at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  // Expected architectural state of each node
  logic [63:0] m_data [2];
  logic [3:0]  m_src  [2];
  logic [7:0]  m_good [2];
  logic [7:0]  m_errc [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] crc4_model(input logic [71:0] bits);
    logic [3:0] c = 4'b0000;
    logic       fb;
    for (int i = 71; i >= 0; i--) begin
      fb = bits[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_data[n] = '0;
      m_src[n]  = '0;
      m_good[n] = '0;
      m_errc[n] = '0;
    end
  endtask

  // Queue the response each node owes for a frame whose start bit was sampled at start_cyc.
  task automatic expect_frame(input logic [3:0] src, input logic [3:0] dst,
                              input logic [63:0] data, input bit good,
                              input int unsigned start_cyc);
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      bit push = 1'b0;
      if (!good) begin
        m_errc[n] = sat_inc(m_errc[n]);
        push = 1'b1;
      end else if (dst == 4'd1 || n == 1) begin
        m_good[n] = sat_inc(m_good[n]);
        m_data[n] = data;
        m_src[n]  = src;
        push = 1'b1;
      end
      if (push) begin
        e.is_err = !good;
        e.data   = m_data[n];
        e.src    = m_src[n];
        e.good   = m_good[n];
        e.errc   = m_errc[n];
        e.at     = start_cyc + 77;
        if (n == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  // Sends one frame followed by exactly one idle-0 bit.
  task automatic send_frame(input logic [3:0] src, input logic [3:0] dst,
                            input logic [63:0] data, input logic [3:0] crc, input bit good);
    logic [76:0] frame;
    frame = {1'b1, src, dst, data, crc};
    for (int i = 76; i >= 0; i--) begin
      bus_in = frame[i];
      @(posedge clock);
      #1;
      if (i == 76) expect_frame(src, dst, data, good, cyc);
    end
    bus_in = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int n);
    repeat (n) @(posedge clock);
    #1;
    chk("node0 pending pulses", 64'(q0.size()), 64'd0);
    chk("node1 pending pulses", 64'(q1.size()), 64'd0);
  endtask

  task automatic monitor(input int idx, input logic v, input logic e, input logic [63:0] d,
                         input logic [3:0] s, input logic [7:0] g, input logic [7:0] ec);
    exp_t x;
    bit   have;
    if (v || e) begin
      have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        n_checks++;
        n_errors++;
        $display("FAIL node%0d unexpected pulse: got valid=%0b crc_err=%0b expected none (cycle %0d)",
                 idx, v, e, cyc);
      end else begin
        x = (idx == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("node%0d rx_valid", idx), 64'(v), 64'(!x.is_err));
        chk($sformatf("node%0d crc_err", idx), 64'(e), 64'(x.is_err));
        chk($sformatf("node%0d rx_data", idx), d, x.data);
        chk($sformatf("node%0d rx_src", idx), 64'(s), 64'(x.src));
        chk($sformatf("node%0d good_cnt", idx), 64'(g), 64'(x.good));
        chk($sformatf("node%0d err_cnt", idx), 64'(ec), 64'(x.errc));
        chk($sformatf("node%0d pulse cycle", idx), 64'(cyc), 64'(x.at));
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      monitor(0, r0_valid, r0_err, r0_data, r0_src, r0_good, r0_errc);
      monitor(1, r1_valid, r1_err, r1_data, r1_src, r1_good, r1_errc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [76:0] frame;
    logic [63:0] vdata;

    model_reset();
    reset  = 1'b1;
    bus_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("reset busy", 64'(r0_busy), 64'd0);
    chk("reset rx_valid", 64'(r0_valid), 64'd0);
    chk("reset crc_err", 64'(r0_err), 64'd0);
    chk("reset rx_data", r0_data, 64'd0);
    chk("reset good_cnt", 64'(r0_good), 64'd0);
    chk("reset err_cnt", 64'(r0_errc), 64'd0);
    repeat (2) @(posedge clock);
    #1;

    // 1: all-zero payload to this node
    send_frame(4'h0, 4'h1, 64'h0, 4'b0101, 1'b1);
    wait_drain(4);

    // 2: payload 1 good, then same frame with bad CRC
    send_frame(4'h0, 4'h1, 64'h1, 4'b0110, 1'b1);
    wait_drain(4);
    send_frame(4'h0, 4'h1, 64'h1, 4'b0111, 1'b0);
    wait_drain(4);
    chk("rx_data held after crc error", r0_data, 64'h1);

    // 3: good CRC for another node: node0 silent, promiscuous node accepts
    send_frame(4'h0, 4'h2, 64'h0, 4'b1010, 1'b1);
    wait_drain(4);
    chk("filtered good_cnt unchanged", 64'(r0_good), 64'd2);
    chk("filtered err_cnt unchanged", 64'(r0_errc), 64'd1);

    // Non-trivial payload and source
    vdata = 64'h0123_4567_89AB_CDEF;
    send_frame(4'hA, 4'h1, vdata, crc4_model({4'hA, 4'h1, vdata}), 1'b1);
    wait_drain(4);

    // 4: two frames separated by one idle bit
    send_frame(4'h0, 4'h1, 64'h0, 4'b0101, 1'b1);
    send_frame(4'h0, 4'h1, 64'h1, 4'b0110, 1'b1);
    wait_drain(4);

    // 5: reset on data bit 30 of a frame
    frame = {1'b1, 4'h5, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0};
    for (int b = 0; b < 40; b++) begin
      bus_in = frame[76-b];
      if (b == 39) begin
        chk("busy mid-frame", 64'(r0_busy), 64'd1);
        reset = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    reset  = 1'b0;
    bus_in = 1'b0;
    model_reset();
    chk("mid-frame reset busy", 64'(r0_busy), 64'd0);
    chk("mid-frame reset rx_data", r0_data, 64'd0);
    chk("mid-frame reset rx_src", 64'(r0_src), 64'd0);
    chk("mid-frame reset good_cnt", 64'(r0_good), 64'd0);
    chk("mid-frame reset promisc good_cnt", 64'(r1_good), 64'd0);
    chk("mid-frame reset err_cnt", 64'(r0_errc), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    send_frame(4'h3, 4'h1, 64'h0, crc4_model({4'h3, 4'h1, 64'h0}), 1'b1);
    wait_drain(4);

    // 6: 257 CRC-error frames saturate err_cnt
    for (int k = 0; k < 257; k++) begin
      send_frame(4'h0, 4'h1, 64'h0, 4'b0000, 1'b0);
    end
    wait_drain(4);
    chk("err_cnt saturated", 64'(r0_errc), 64'hFF);
    chk("promisc err_cnt saturated", 64'(r1_errc), 64'hFF);
    chk("idle busy at end", 64'(r0_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
